// File: rtl/br_exec_pkg.sv
// Types and limits shared by the branch/compare execution pipe.
package br_exec_pkg;

  localparam int BR_EXEC_MAX_STAGES = 4;
  localparam int BR_XLEN      = 32;
  localparam int BR_ROB_IDX_W = 5;
  localparam int BR_PREG_W    = 6;

  typedef enum logic [1:0] {
    BK_BRANCH = 2'd0,
    BK_JAL    = 2'd1,
    BK_JALR   = 2'd2,
    BK_CMP    = 2'd3
  } br_kind_t;

  // Result payload at the default core widths; the valid bit travels separately.
  typedef struct packed {
    logic [BR_ROB_IDX_W-1:0] rob_idx;
    logic [BR_PREG_W-1:0]    pd;
    logic [BR_XLEN-1:0]      rd_v;
    logic                    taken;
    logic [BR_XLEN-1:0]      next_pc;
    logic                    mispredict;
  } br_slot_t;

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I encodings used by the execution units.
package rv32i_types;

  // funct3 codes of the conditional branches; SLT/SLTU reuse BLT/BLTU.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_f3_t;

endpackage

// File: rtl/br_exec_pipe_resolve.sv
// br_resolve: combinational compare, target, direction and mispredict evaluation.
module br_resolve
  import rv32i_types::*;
  import br_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  br_kind_t         kind_i,
  input  branch_f3_t       cmp_op_i,
  input  logic             use_imm_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  rs1_v_i,
  input  logic [XLEN-1:0]  rs2_v_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_target_i,
  output logic [XLEN-1:0]  rd_v_o,
  output logic             taken_o,
  output logic [XLEN-1:0]  next_pc_o,
  output logic             mispredict_o
);

  logic [XLEN-1:0]        cmp_b;
  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] cmp_b_s;
  logic [XLEN-1:0]        seq_pc;
  logic [XLEN-1:0]        jalr_sum;
  logic [XLEN-1:0]        target;
  logic                   cmp;

  assign cmp_b    = use_imm_i ? imm_i : rs2_v_i;
  assign rs1_s    = rs1_v_i;
  assign cmp_b_s  = cmp_b;
  assign seq_pc   = pc_i + XLEN'(4);
  assign jalr_sum = rs1_v_i + imm_i;
  assign target   = (kind_i == BK_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_i + imm_i;

  always_comb begin
    cmp = 1'b0;
    case (cmp_op_i)
      BR_BEQ:  cmp = (rs1_v_i == cmp_b);
      BR_BNE:  cmp = (rs1_v_i != cmp_b);
      BR_BLT:  cmp = (rs1_s <  cmp_b_s);
      BR_BGE:  cmp = (rs1_s >= cmp_b_s);
      BR_BLTU: cmp = (rs1_v_i <  cmp_b);
      BR_BGEU: cmp = (rs1_v_i >= cmp_b);
      default: cmp = 1'b0;
    endcase
  end

  always_comb begin
    taken_o = 1'b0;
    rd_v_o  = '0;
    case (kind_i)
      BK_BRANCH: taken_o = cmp;
      BK_JAL, BK_JALR: begin
        taken_o = 1'b1;
        rd_v_o  = seq_pc;
      end
      BK_CMP:    rd_v_o = {{(XLEN-1){1'b0}}, cmp};
      default: begin
        taken_o = 1'b0;
        rd_v_o  = '0;
      end
    endcase
  end

  assign next_pc_o    = taken_o ? target : seq_pc;
  assign mispredict_o = (kind_i != BK_CMP) &
                        ((pred_taken_i != taken_o) | (taken_o & (pred_target_i != target)));

endmodule

// File: rtl/br_exec_pipe.sv
// br_exec_pipe: pipelined branch/compare unit with valid/ready in and out.
// Optional perf counters on the output handshake when BR_EXEC_PERF_EN is defined.
module br_exec_pipe
  import rv32i_types::*;
  import br_exec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STAGES    = 2,
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  br_kind_t             in_kind,
  input  branch_f3_t           in_cmp_op,
  input  logic                 in_use_imm,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [XLEN-1:0]      in_rs1_v,
  input  logic [XLEN-1:0]      in_rs2_v,
  input  logic                 in_pred_taken,
  input  logic [XLEN-1:0]      in_pred_target,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [PREG_W-1:0]    in_pd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic [PREG_W-1:0]    out_pd,
  output logic [XLEN-1:0]      out_rd_v,
  output logic                 out_taken,
  output logic [XLEN-1:0]      out_next_pc,
  output logic                 out_mispredict
`ifdef BR_EXEC_PERF_EN
  ,
  output logic [31:0]          perf_branches,
  output logic [31:0]          perf_taken,
  output logic [31:0]          perf_mispredicts
`endif
);

  if (STAGES < 1 || STAGES > BR_EXEC_MAX_STAGES) begin : g_bad_stages
    $error("br_exec_pipe: STAGES out of range");
  end

  // Same layout as br_slot_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    pd;
    logic [XLEN-1:0]      rd_v;
    logic                 taken;
    logic [XLEN-1:0]      next_pc;
    logic                 mispredict;
  } slot_t;

  slot_t             slot_d;
  slot_t             slot_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] en;
  logic              any_hole;

  br_resolve #(.XLEN(XLEN)) u_resolve (
    .kind_i        (in_kind),
    .cmp_op_i      (in_cmp_op),
    .use_imm_i     (in_use_imm),
    .pc_i          (in_pc),
    .imm_i         (in_imm),
    .rs1_v_i       (in_rs1_v),
    .rs2_v_i       (in_rs2_v),
    .pred_taken_i  (in_pred_taken),
    .pred_target_i (in_pred_target),
    .rd_v_o        (slot_d.rd_v),
    .taken_o       (slot_d.taken),
    .next_pc_o     (slot_d.next_pc),
    .mispredict_o  (slot_d.mispredict)
  );

  assign slot_d.rob_idx = in_rob_idx;
  assign slot_d.pd      = in_pd;

  // A slot may load when it or any slot downstream of it is empty, or the CDB takes the head.
  always_comb begin
    any_hole = 1'b0;
    en       = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      any_hole = any_hole | ~vld_q[i];
      en[i]    = out_ready | any_hole;
    end
  end

  assign in_ready = en[0];

  // ---- slot 0 capture, slots 1..STAGES-1 shift ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) slot_q[i] <= '0;
    end else begin
      if (en[0]) begin
        vld_q[0]  <= in_valid;
        slot_q[0] <= slot_d;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (en[i]) begin
          vld_q[i]  <= vld_q[i-1];
          slot_q[i] <= slot_q[i-1];
        end
      end
      if (flush) vld_q <= '0;
    end
  end

  // ---- output head ----
  assign out_valid      = vld_q[STAGES-1];
  assign out_rob_idx    = slot_q[STAGES-1].rob_idx;
  assign out_pd         = slot_q[STAGES-1].pd;
  assign out_rd_v       = slot_q[STAGES-1].rd_v;
  assign out_taken      = slot_q[STAGES-1].taken;
  assign out_next_pc    = slot_q[STAGES-1].next_pc;
  assign out_mispredict = slot_q[STAGES-1].mispredict;

`ifdef BR_EXEC_PERF_EN
  logic [STAGES-1:0] is_br_q;
  logic [31:0]       perf_br_q;
  logic [31:0]       perf_tk_q;
  logic [31:0]       perf_mp_q;
  logic              out_fire;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_br_q   <= '0;
      perf_br_q <= '0;
      perf_tk_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (en[0]) is_br_q[0] <= (in_kind != BK_CMP);
      for (int i = 1; i < STAGES; i++) begin
        if (en[i]) is_br_q[i] <= is_br_q[i-1];
      end
      perf_br_q <= sat_inc(perf_br_q, out_fire & is_br_q[STAGES-1]);
      perf_tk_q <= sat_inc(perf_tk_q, out_fire & out_taken);
      perf_mp_q <= sat_inc(perf_mp_q, out_fire & out_mispredict);
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_taken       = perf_tk_q;
  assign perf_mispredicts = perf_mp_q;
`endif

endmodule

// File: tb/tb_br_exec_pipe.sv
// Bench for br_exec_pipe: directed vectors plus a queue-based reference model.
module tb_br_exec_pipe;
  import rv32i_types::*;
  import br_exec_pkg::*;

  localparam int STAGES = 2;
  localparam int STALL  = (STAGES + 2 > 4) ? STAGES + 2 : 4;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic        use_imm;
    logic [31:0] pc, imm, rs1, rs2;
    logic        pt;
    logic [31:0] ptgt;
    logic [4:0]  rob;
    logic [5:0]  pd;
  } op_t;

  typedef struct packed {
    logic [31:0] rd, npc;
    logic        tk, mp, br;
    logic [4:0]  rob;
    logic [5:0]  pd;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_taken, out_mispredict;
  logic [4:0]  out_rob_idx;
  logic [5:0]  out_pd;
  logic [31:0] out_rd_v, out_next_pc;
  op_t         cur;
  op_t         ops [6];
  res_t        exp_q [$];
  res_t        prev;
  bit          have_prev;
  int          errors = 0;
  int          checks = 0;
  int          m_br = 0, m_tk = 0, m_mp = 0;
`ifdef BR_EXEC_PERF_EN
  logic [31:0] perf_branches, perf_taken, perf_mispredicts;
`endif

  br_exec_pipe #(.XLEN(32), .STAGES(STAGES), .ROB_IDX_W(5), .PREG_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_kind        (br_kind_t'(cur.kind)),
    .in_cmp_op      (branch_f3_t'(cur.f3)),
    .in_use_imm     (cur.use_imm),
    .in_pc          (cur.pc),
    .in_imm         (cur.imm),
    .in_rs1_v       (cur.rs1),
    .in_rs2_v       (cur.rs2),
    .in_pred_taken  (cur.pt),
    .in_pred_target (cur.ptgt),
    .in_rob_idx     (cur.rob),
    .in_pd          (cur.pd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rob_idx    (out_rob_idx),
    .out_pd         (out_pd),
    .out_rd_v       (out_rd_v),
    .out_taken      (out_taken),
    .out_next_pc    (out_next_pc),
    .out_mispredict (out_mispredict)
`ifdef BR_EXEC_PERF_EN
    ,
    .perf_branches    (perf_branches),
    .perf_taken       (perf_taken),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic op_t mk(input logic [1:0] k, input logic [2:0] f3, input logic ui,
                             input logic [31:0] pc, imm, rs1, rs2, input logic pt,
                             input logic [31:0] ptgt, input logic [4:0] rob, input logic [5:0] pd);
    op_t o;
    o.kind = k; o.f3 = f3; o.use_imm = ui; o.pc = pc; o.imm = imm;
    o.rs1 = rs1; o.rs2 = rs2; o.pt = pt; o.ptgt = ptgt; o.rob = rob; o.pd = pd;
    return o;
  endfunction

  // Reference: RV32I semantics using 64-bit signed arithmetic for signed compares.
  function automatic res_t model(input op_t o);
    res_t        r;
    logic [31:0] b, tgt, seq;
    longint      sa, sb;
    bit          c;
    b   = o.use_imm ? o.imm : o.rs2;
    sa  = longint'($signed(o.rs1));
    sb  = longint'($signed(b));
    case (o.f3)
      3'd0: c = (o.rs1 == b);
      3'd1: c = (o.rs1 != b);
      3'd4: c = (sa < sb);
      3'd5: c = (sa >= sb);
      3'd6: c = (o.rs1 < b);
      3'd7: c = (o.rs1 >= b);
      default: c = 1'b0;
    endcase
    seq = o.pc + 32'd4;
    tgt = (o.kind == 2'd2) ? ((o.rs1 + o.imm) & 32'hFFFF_FFFE) : (o.pc + o.imm);
    case (o.kind)
      2'd0:    begin r.tk = c;    r.rd = 32'd0; end
      2'd3:    begin r.tk = 1'b0; r.rd = {31'd0, c}; end
      default: begin r.tk = 1'b1; r.rd = seq; end
    endcase
    r.npc = r.tk ? tgt : seq;
    r.mp  = (o.kind == 2'd3) ? 1'b0 : ((o.pt != r.tk) || (r.tk && (o.ptgt != tgt)));
    r.br  = (o.kind != 2'd3);
    r.rob = o.rob;
    r.pd  = o.pd;
    return r;
  endfunction

  // Scoreboard: pops on output handshake, checks stall stability, pushes accepted ops.
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      exp_q.delete();
      have_prev = 1'b0;
      m_br = 0; m_tk = 0; m_mp = 0;
    end else begin
      if (have_prev) begin
        chk("stall_valid", 64'(out_valid), 64'(1'b1));
        chk("stall_rob", 64'(out_rob_idx), 64'(prev.rob));
        chk("stall_pd", 64'(out_pd), 64'(prev.pd));
        chk("stall_rd", 64'(out_rd_v), 64'(prev.rd));
        chk("stall_npc", 64'(out_next_pc), 64'(prev.npc));
        chk("stall_tk", 64'(out_taken), 64'(prev.tk));
        chk("stall_mp", 64'(out_mispredict), 64'(prev.mp));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got rob %0h, want no result", out_rob_idx);
        end else begin
          e = exp_q.pop_front();
          chk("out_rob", 64'(out_rob_idx), 64'(e.rob));
          chk("out_pd", 64'(out_pd), 64'(e.pd));
          chk("out_rd", 64'(out_rd_v), 64'(e.rd));
          chk("out_npc", 64'(out_next_pc), 64'(e.npc));
          chk("out_tk", 64'(out_taken), 64'(e.tk));
          chk("out_mp", 64'(out_mispredict), 64'(e.mp));
          m_br += int'(e.br); m_tk += int'(e.tk); m_mp += int'(e.mp);
        end
      end
      have_prev = out_valid && !out_ready && !flush;
      prev.rob = out_rob_idx; prev.pd = out_pd; prev.rd = out_rd_v;
      prev.npc = out_next_pc; prev.tk = out_taken; prev.mp = out_mispredict; prev.br = 1'b0;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(cur));
    end
  end

  task automatic single(input string nm, input op_t o, input logic [31:0] e_rd, e_npc,
                        input logic e_tk, e_mp);
    cur = o;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (STAGES - 1) @(posedge clk);
    #1;
    chk({nm, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({nm, "_rd"}, 64'(out_rd_v), 64'(e_rd));
    chk({nm, "_npc"}, 64'(out_next_pc), 64'(e_npc));
    chk({nm, "_tk"}, 64'(out_taken), 64'(e_tk));
    chk({nm, "_mp"}, 64'(out_mispredict), 64'(e_mp));
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n, input int stall);
    int k = 0, cyc = 0, acc = 0;
    out_ready = (stall == 0);
    while (k < n && cyc < 200) begin
      cur = ops[k];
      in_valid = 1'b1;
      @(negedge clk);
      if (cyc < stall && in_ready) acc++;
      if (cyc == stall - 1) begin
        chk("stall_in_ready", 64'(in_ready), 64'(1'b0));
        chk("stall_accepts", 64'(acc), 64'(STAGES));
      end
      if (in_ready) k++;
      @(posedge clk); #1;
      cyc++;
      if (cyc >= stall) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    chk("stream_sent", 64'(k), 64'(n));
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill_full();
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      cur = ops[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cur = '0;
    ops[0] = mk(BK_BRANCH, BR_BNE,  1'b0, 32'h40,   32'h8,   32'd7,        32'd7,        1'b1, 32'h48,  5'd1, 6'd11);
    ops[1] = mk(BK_BRANCH, BR_BGE,  1'b0, 32'h50,   32'h10,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 32'h60,  5'd2, 6'd12);
    ops[2] = mk(BK_BRANCH, BR_BLTU, 1'b0, 32'h60,   32'h4,   32'h8000_0000, 32'd1,        1'b0, 32'h0,   5'd3, 6'd13);
    ops[3] = mk(BK_BRANCH, BR_BGEU, 1'b0, 32'h70,   32'h40,  32'h8000_0000, 32'd1,        1'b0, 32'h0,   5'd4, 6'd14);
    ops[4] = mk(BK_JAL,    BR_BEQ,  1'b0, 32'h1000, 32'hFFFF_FFF0, 32'd0,    32'd0,        1'b1, 32'hFF4, 5'd5, 6'd15);
    ops[5] = mk(BK_CMP,    BR_BLT,  1'b1, 32'h80,   32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,   1'b0, 32'h0,   5'd6, 6'd16);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_out_rd", 64'(out_rd_v), 64'd0);
    chk("rst_out_npc", 64'(out_next_pc), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'(1'b1));

    single("beq", mk(BK_BRANCH, BR_BEQ, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0, 5'd7, 6'd20),
           32'h0, 32'h120, 1'b1, 1'b1);
    single("jalr", mk(BK_JALR, BR_BEQ, 1'b0, 32'h200, 32'h4, 32'h1001, 32'd0, 1'b1, 32'h1004, 5'd8, 6'd21),
           32'h204, 32'h1004, 1'b1, 1'b0);
    single("sltiu", mk(BK_CMP, BR_BLTU, 1'b1, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'h0, 5'd9, 6'd22),
           32'h1, 32'h304, 1'b0, 1'b0);
    single("slt", mk(BK_CMP, BR_BLT, 1'b0, 32'h400, 32'h0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 5'd10, 6'd23),
           32'h1, 32'h404, 1'b0, 1'b0);
    single("blt_wrap", mk(BK_BRANCH, BR_BLT, 1'b0, 32'hFFFF_FFFC, 32'h40, 32'd5, 32'd3, 1'b0, 32'h0, 5'd11, 6'd24),
           32'h0, 32'h0, 1'b0, 1'b0);
    single("jal", mk(BK_JAL, BR_BEQ, 1'b0, 32'h300, 32'h10, 32'd0, 32'd0, 1'b1, 32'h314, 5'd12, 6'd25),
           32'h304, 32'h310, 1'b1, 1'b1);
    single("bad_f3", mk(BK_BRANCH, 3'b010, 1'b0, 32'h500, 32'h8, 32'd1, 32'd1, 1'b1, 32'h508, 5'd13, 6'd26),
           32'h0, 32'h504, 1'b0, 1'b1);

    stream(6, STALL);
    drain();

    fill_full();
    chk("full_in_ready", 64'(in_ready), 64'(1'b0));
    cur = mk(BK_JAL, BR_BEQ, 1'b0, 32'h900, 32'h4, 32'd0, 32'd0, 1'b0, 32'h0, 5'h1F, 6'h3F);
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'(1'b0));
    repeat (STAGES + 3) @(posedge clk);
    #1;
    chk("flush_quiet", 64'(out_valid), 64'(1'b0));

    fill_full();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("arst_in_ready", 64'(in_ready), 64'(1'b1));
`ifdef BR_EXEC_PERF_EN
    chk("arst_perf_br", 64'(perf_branches), 64'd0);
    chk("arst_perf_tk", 64'(perf_taken), 64'd0);
    chk("arst_perf_mp", 64'(perf_mispredicts), 64'd0);
`endif
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    stream(6, 0);
    drain();
`ifdef BR_EXEC_PERF_EN
    chk("perf_br", 64'(perf_branches), 64'(m_br));
    chk("perf_tk", 64'(perf_taken), 64'(m_tk));
    chk("perf_mp", 64'(perf_mispredicts), 64'(m_mp));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
